// File: rtl/tile_menu_renderer_if.sv
// Memory-side bus of tile_menu_renderer: tile-buffer read port and glyph-ROM read port.
// Both memories return data one clock after the address.
interface tile_menu_renderer_if;
  logic [9:0]  buf_read_addr_out;
  logic [7:0]  buf_read_data_in;
  logic [11:0] tile_addr_out;
  logic [7:0]  tile_row_in;

  modport master (
    output buf_read_addr_out,
    output tile_addr_out,
    input  buf_read_data_in,
    input  tile_row_in
  );

  modport slave (
    input  buf_read_addr_out,
    input  tile_addr_out,
    output buf_read_data_in,
    output tile_row_in
  );
endinterface

// File: rtl/tile_menu_renderer.sv
// Parametrised tile-grid menu renderer: hcount/vcount -> buffer/ROM addresses -> 24-bit pixel, 3-clk latency.
// Optional blinking cursor is enabled by defining MENU_BLINK_EN.
module tile_menu_renderer #(
  parameter int unsigned TILE_LOG2    = 5,
  parameter int unsigned COLS         = 40,
  parameter int unsigned ROWS         = 23,
  parameter int unsigned PTR_PER_COL  = 8,
  parameter int unsigned PTR_COUNT    = 12,
  parameter int unsigned CUR_COL0     = 1,
  parameter int unsigned CUR_COL_STEP = 20,
  parameter int unsigned CUR_ROW0     = 3,
  parameter int unsigned CUR_ROW_STEP = 2,
  parameter logic [63:0] CURSOR_GLYPH = 64'h00103070F0703010,
  parameter logic [23:0] FG_COLOR     = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR     = 24'h000000,
  parameter logic [23:0] GRID_COLOR   = 24'h444444,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [10:0]                  hcount_in,
  input  logic [9:0]                   vcount_in,
  input  logic                         grid_en_in,
  input  logic [3:0]                   ptr_index_in,
  tile_menu_renderer_if.master         mem,
  output logic [23:0]                  pixel_out
);

  if (TILE_LOG2 < 3 || BLINK_FRAMES == 0) begin : g_param_check
    $error("tile_menu_renderer: TILE_LOG2 must be >= 3 and BLINK_FRAMES >= 1");
  end

  logic [10:0] h1, h2;
  logic [9:0]  v1, v2;
  logic        inr1, inr2, attr2;
  logic [3:0]  ptr_q;
  logic        cursor_vis;

  int unsigned col0, row0, col2, row2, cur_col, cur_row;
  logic        inr0, frame_start, in_cursor, grid2, cur_bit, glyph_bit;
  logic [2:0]  gx2, gy2;
  logic [23:0] pix_d;

  assign frame_start = (hcount_in == '0) && (vcount_in == '0);

  // Stage 0: tile-buffer address
  always_comb begin
    col0 = 32'(hcount_in) >> TILE_LOG2;
    row0 = 32'(vcount_in) >> TILE_LOG2;
    inr0 = (col0 < COLS) && (row0 < ROWS);
    mem.buf_read_addr_out = inr0 ? 10'(row0 * COLS + col0) : '0;
  end

  // Stage 1: glyph-ROM address; bit 7 of the byte is the invert attribute, not part of the glyph code
  assign mem.tile_addr_out = {mem.buf_read_data_in[6:0], v1[TILE_LOG2-1 -: 3]};

  // Stage 2: colour selection
  always_comb begin
    col2      = 32'(h2) >> TILE_LOG2;
    row2      = 32'(v2) >> TILE_LOG2;
    gx2       = h2[TILE_LOG2-1 -: 3];
    gy2       = v2[TILE_LOG2-1 -: 3];
    cur_col   = CUR_COL0 + (32'(ptr_q) / PTR_PER_COL) * CUR_COL_STEP;
    cur_row   = CUR_ROW0 + (32'(ptr_q) % PTR_PER_COL) * CUR_ROW_STEP;
    in_cursor = (32'(ptr_q) < PTR_COUNT) && (col2 == cur_col) && (row2 == cur_row);
    grid2     = grid_en_in && ((h2[TILE_LOG2-1:0] == '0) || (v2[TILE_LOG2-1:0] == '0));
    cur_bit   = CURSOR_GLYPH[{gy2, gx2}];
    glyph_bit = mem.tile_row_in[~gx2] ^ attr2;
    pix_d     = BG_COLOR;
    if (!inr2)
      pix_d = BG_COLOR;
    else if (grid2)
      pix_d = GRID_COLOR;
    else if (in_cursor && cur_bit && cursor_vis)
      pix_d = FG_COLOR;
    else if (glyph_bit)
      pix_d = FG_COLOR;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      h1        <= '0;
      v1        <= '0;
      inr1      <= 1'b0;
      h2        <= '0;
      v2        <= '0;
      inr2      <= 1'b0;
      attr2     <= 1'b0;
      pixel_out <= '0;
      ptr_q     <= '1;
    end else begin
      h1        <= hcount_in;
      v1        <= vcount_in;
      inr1      <= inr0;
      h2        <= h1;
      v2        <= v1;
      inr2      <= inr1;
      attr2     <= mem.buf_read_data_in[7];
      pixel_out <= pix_d;
      if (frame_start)
        ptr_q <= ptr_index_in;
    end
  end

`ifdef MENU_BLINK_EN
  localparam int unsigned CNT_W = $clog2(BLINK_FRAMES) + 1;
  logic [CNT_W-1:0] blink_cnt;

  // A newly selected slot restarts the blink so the cursor shows immediately after a move
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      blink_cnt  <= '0;
      cursor_vis <= 1'b1;
    end else if (frame_start) begin
      if (ptr_index_in != ptr_q) begin
        blink_cnt  <= '0;
        cursor_vis <= 1'b1;
      end else if (32'(blink_cnt) == BLINK_FRAMES - 1) begin
        blink_cnt  <= '0;
        cursor_vis <= ~cursor_vis;
      end else begin
        blink_cnt <= blink_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign cursor_vis = 1'b1;
`endif

endmodule
